// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM state encoding,
// default operand/result sizes and the largest value representable in BCD.
package bcd_pkg;

  localparam int DEF_WIDTH  = 14;
  localparam int DEF_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest value that fits in 'digits' BCD digits: 10^digits - 1.
  function automatic longint unsigned bcd_max(input int digits);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/shift_add3.sv
// Per-digit double-dabble correction: a digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
// Inputs are always 0..9, so the result never exceeds 12 and fits in 4 bits.
module shift_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// A conversion is started from IDLE, runs WIDTH shift cycles in CONV, then
// publishes the result from DONE with a one-cycle done pulse.
//
// Handshake: start is only looked at while busy=0 (IDLE); a start seen there
// captures bin on that edge. done is a single-cycle pulse; bcd/ovf stay valid
// and stable until the next done pulse (or reset).
//
// Optional feature: define BIN2BCD_OVF_SAT_EN to saturate bcd to all 9s and
// flag ovf when bin exceeds 10^DIGITS-1. Without it, ovf is tied low and bcd
// holds bin mod 10^DIGITS.
module bin2bcd_ctrl
  import bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;

`ifdef BIN2BCD_OVF_SAT_EN
  localparam longint unsigned MAXV = bcd_max(DIGITS);
  // Overflow is only reachable when some WIDTH-bit value exceeds MAXV.
  localparam bit OVF_POSSIBLE = ($clog2(MAXV + 2) <= WIDTH);
  localparam logic [WIDTH-1:0] MAX_W = OVF_POSSIBLE ? WIDTH'(MAXV) : '1;
  logic ovf_pend;
`endif

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] sr;
  logic [SW-1:0]   scratch;
  logic [SW-1:0]   adj;

  // Add-3 correction for every scratch digit ahead of the shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    shift_add3 u_add3 (
      .d (scratch[4*i +: 4]),
      .q (adj[4*i +: 4])
    );
  end

`ifndef BIN2BCD_OVF_SAT_EN
  assign ovf = 1'b0;
`endif

  // Control FSM and datapath: load, WIDTH shift cycles, then publish result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      cnt     <= '0;
      scratch <= '0;
      sr      <= '0;
`ifdef BIN2BCD_OVF_SAT_EN
      ovf      <= 1'b0;
      ovf_pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr      <= bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
            state   <= CONV;
`ifdef BIN2BCD_OVF_SAT_EN
            ovf_pend <= OVF_POSSIBLE && (bin > MAX_W);
`endif
          end
        end
        CONV: begin
          // Bits leaving the top digit are dropped: result is mod 10^DIGITS.
          {scratch, sr} <= {adj, sr} << 1;
          cnt           <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
`ifdef BIN2BCD_OVF_SAT_EN
          if (ovf_pend) begin
            bcd <= {DIGITS{4'h9}};
            ovf <= 1'b1;
          end else begin
            bcd <= scratch;
            ovf <= 1'b0;
          end
`else
          bcd <= scratch;
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
